// File: rtl/motor_status_reporter_if.sv
// Byte stream from the motor status reporter to the host-link transmitter.
// A byte moves on a rising edge where tx_valid && tx_ready. Once tx_valid is raised, tx_data holds until that transfer.
interface motor_status_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/motor_status_reporter.sv
// Reports the six motor enable levels to the host as 3-byte frames {HEADER, status, HEADER^status}.
// A frame is sent on an enable change, a host request, or a heartbeat timeout.
module motor_status_reporter #(
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned PERIOD_CYCLES = 50000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           EN1,
  input  logic                           EN2,
  input  logic                           EN3,
  input  logic                           EN4,
  input  logic                           EN5,
  input  logic                           EN6,
  input  logic                           req,
  output logic                           busy,
  output logic [1:0]                     state_dbg,
  motor_status_reporter_if.master        tx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    STAT = 2'd2,
    SUM  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [5:0]       snap;
  logic [5:0]       last_rep;
  logic [7:0]       status;
  logic [7:0]       status_next;
  logic             pend_req;
  logic             pend_per;
  logic [CNT_W-1:0] timer;
  logic [7:0]       data_q, data_next;
  logic             valid_q, valid_next;
  logic [1:0]       reason;
  logic             chg;
  logic             start;
  logic             xfer;
  logic             timer_tc;

  assign chg      = (snap != last_rep);
  assign start    = (state == IDLE) && (chg || pend_req || pend_per || req);
  assign xfer     = valid_q && tx.tx_ready;
  assign timer_tc = (timer == CNT_W'(PERIOD_CYCLES - 1));

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  always_comb begin
    state_next = state;
    data_next  = data_q;
    valid_next = valid_q;
    // Coincident triggers collapse into one frame tagged with the highest-priority reason.
    if (chg)                  reason = 2'b01;
    else if (pend_req || req) reason = 2'b10;
    else                      reason = 2'b11;
    status_next = {reason, snap};
    case (state)
      IDLE: if (start) begin
        state_next = HDR;
        data_next  = HEADER;
        valid_next = 1'b1;
      end
      HDR: if (xfer) begin
        state_next = STAT;
        data_next  = status;
      end
      STAT: if (xfer) begin
        state_next = SUM;
        data_next  = HEADER ^ status;
      end
      SUM: if (xfer) begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      snap     <= 6'd0;
      last_rep <= 6'd0;
      status   <= 8'h00;
      pend_req <= 1'b0;
      pend_per <= 1'b0;
      timer    <= '0;
    end else begin
      state   <= state_next;
      data_q  <= data_next;
      valid_q <= valid_next;
      snap    <= {EN6, EN5, EN4, EN3, EN2, EN1};
      if (start) begin
        // Frame start consumes every pending trigger, including a req on this same edge.
        status   <= status_next;
        last_rep <= snap;
        pend_req <= 1'b0;
        pend_per <= 1'b0;
        timer    <= '0;
      end else begin
        if (req) pend_req <= 1'b1;
        if (timer_tc) begin
          timer    <= '0;
          pend_per <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_status_reporter.sv
// Directed bench for motor_status_reporter with a short heartbeat period.
module tb_motor_status_reporter;

  localparam logic [7:0] HDR_B = 8'hA5;

  logic       clock;
  logic       reset;
  logic [5:0] en;
  logic       req;
  logic       busy;
  logic [1:0] state_dbg;

  motor_status_reporter_if tx_if ();

  motor_status_reporter #(
    .HEADER        (HDR_B),
    .PERIOD_CYCLES (20),
    .CNT_W         (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .EN1       (en[0]),
    .EN2       (en[1]),
    .EN3       (en[2]),
    .EN4       (en[3]),
    .EN5       (en[4]),
    .EN6       (en[5]),
    .req       (req),
    .busy      (busy),
    .state_dbg (state_dbg),
    .tx        (tx_if.master)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 6'd0;
    req = 1'b0;
    tx_if.tx_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: queue the three expected bytes and check each transfer within a cycle budget.
  task automatic run_frame(input string tag, input logic [7:0] status, input int budget);
    logic [7:0] e;
    exp_q.push_back(HDR_B);
    exp_q.push_back(status);
    exp_q.push_back(HDR_B ^ status);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        e = exp_q.pop_front();
        check_eq(tag, {24'd0, tx_if.tx_data}, {24'd0, e});
      end
      tick();
    end
    if (exp_q.size() != 0) begin
      check_eq({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    check_eq({tag, "_busy_end"}, {31'd0, busy}, 0);
    check_eq({tag, "_valid_end"}, {31'd0, tx_if.tx_valid}, 0);
  endtask

  initial begin
    int cnt;

    // Reset state
    do_reset();
    check_eq("rst_valid", {31'd0, tx_if.tx_valid}, 0);
    check_eq("rst_data", {24'd0, tx_if.tx_data}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_state", {30'd0, state_dbg}, 0);

    // 1: heartbeat only; expiry on edge 20 sets pend_per, header on edge 21
    repeat (20) tick();
    check_eq("t1_quiet", {31'd0, tx_if.tx_valid}, 0);
    tick();
    check_eq("t1_hdr_valid", {31'd0, tx_if.tx_valid}, 1);
    run_frame("t1_byte", 8'hC0, 3);

    // 2: EN3 rises before edge 5, header after edge 6, three back-to-back bytes
    do_reset();
    repeat (4) tick();
    en = 6'b000100;
    tick();
    check_eq("t2_no_hdr_yet", {31'd0, tx_if.tx_valid}, 0);
    tick();
    check_eq("t2_hdr_valid", {31'd0, tx_if.tx_valid}, 1);
    run_frame("t2_byte", 8'h44, 3);

    // 3: backpressure in STAT holds the status byte
    do_reset();
    en = 6'b000100;
    tick();
    tick();
    check_eq("t3_hdr", {24'd0, tx_if.tx_data}, 32'hA5);
    tick();
    check_eq("t3_stat", {24'd0, tx_if.tx_data}, 32'h44);
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t3_hold_data", {24'd0, tx_if.tx_data}, 32'h44);
      check_eq("t3_hold_valid", {31'd0, tx_if.tx_valid}, 1);
    end
    tx_if.tx_ready = 1'b1;
    tick();
    check_eq("t3_sum", {24'd0, tx_if.tx_data}, 32'hE1);
    tick();
    check_eq("t3_done", {31'd0, busy}, 0);

    // 4: req arrives on the edge the change is first visible; change reason wins
    do_reset();
    tick();
    tick();
    en = 6'b000001;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    check_eq("t4_hdr_valid", {31'd0, tx_if.tx_valid}, 1);
    run_frame("t4_byte", 8'h41, 3);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_if.tx_valid) cnt++;
    end
    check_eq("t4_no_extra", cnt, 0);

    // 5: req during STAT queues a request frame after one idle cycle
    do_reset();
    en = 6'b000100;
    tick();
    tick();
    check_eq("t5_hdr", {24'd0, tx_if.tx_data}, 32'hA5);
    tick();
    check_eq("t5_stat", {24'd0, tx_if.tx_data}, 32'h44);
    req = 1'b1;
    tick();
    req = 1'b0;
    check_eq("t5_sum", {24'd0, tx_if.tx_data}, 32'hE1);
    tick();
    check_eq("t5_gap_valid", {31'd0, tx_if.tx_valid}, 0);
    check_eq("t5_gap_busy", {31'd0, busy}, 0);
    tick();
    check_eq("t5_req_hdr_valid", {31'd0, tx_if.tx_valid}, 1);
    run_frame("t5_byte", 8'h84, 3);

    // 6: reset mid-frame abandons it; last_rep=0 forces a fresh change frame
    do_reset();
    en = 6'b000100;
    tick();
    tick();
    tick();
    check_eq("t6_in_stat", {30'd0, state_dbg}, 2);
    tx_if.tx_ready = 1'b0;
    reset = 1'b1;
    tick();
    check_eq("t6_rst_valid", {31'd0, tx_if.tx_valid}, 0);
    check_eq("t6_rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    tx_if.tx_ready = 1'b1;
    tick();
    check_eq("t6_sample_cycle", {31'd0, tx_if.tx_valid}, 0);
    tick();
    check_eq("t6_hdr_valid", {31'd0, tx_if.tx_valid}, 1);
    run_frame("t6_byte", 8'h44, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/motor_status_reporter.md
Name: motor_status_reporter

Overview:
- Read-back counterpart to the motor enable latch block: samples the six motor enable lines EN1..EN6 and reports their state to the host controller as framed bytes on a valid/ready byte stream.
- A frame is sent when any enable changes, when the host requests it, or when a periodic heartbeat timer expires.
- Sits between the enable latch outputs and the host-link byte transmitter.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- PERIOD_CYCLES, 50000000, heartbeat interval in clock cycles; legal range is 2 or more.
- CNT_W, 26, heartbeat counter width; must satisfy 2^CNT_W >= PERIOD_CYCLES.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- EN1..EN6  in  1 each  motor enable levels, same clock domain.
- req  in  1  host status request; single-cycle pulse.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the byte; a transfer occurs on an edge where tx_valid && tx_ready.
- busy  out  1  high while a frame is in flight (state is not IDLE).

Behaviour:
- Reset values, applied on any edge with reset=1, including mid-frame: tx_valid=0, tx_data=0, busy=0, state=IDLE, snap=0, last_rep=0, pend_req=0, pend_per=0, timer=0. A frame in progress is abandoned with no tail bytes.
- Sampling: snap[5:0] <= {EN6,EN5,EN4,EN3,EN2,EN1} every cycle.
- Change condition: chg = (snap != last_rep), evaluated combinationally.
- Pending flags:
  - pend_req sets on req=1.
  - Timer counts 0..PERIOD_CYCLES-1. At terminal count it wraps to 0 and sets pend_per.
  - Flags are sticky until a frame starts.
- FSM states: IDLE, HDR, STAT, SUM.
- IDLE -> HDR when (chg || pend_req || pend_per || req). At that edge:
  - Latch status = {reason[1:0], snap[5:0]}.
  - Set last_rep <= snap.
  - Clear pend_req and pend_per; a req arriving on that same edge is consumed.
  - Reload timer to 0.
  - Drive tx_data=HEADER and tx_valid=1.
- Reason priority, highest first: change (2'b01), request (2'b10), periodic (2'b11). Only one frame is sent for all coincident triggers.
- HDR -> STAT on transfer: tx_data=status.
- STAT -> SUM on transfer: tx_data = HEADER ^ status.
- SUM -> IDLE on transfer: tx_valid=0 at that edge.
- Backpressure: while tx_valid=1 and tx_ready=0, tx_data and state hold stable. tx_valid is never deasserted without a transfer, except on reset.
- Triggers during a frame:
  - req and heartbeat expiry set their pending flags.
  - EN changes are compared against last_rep on return to IDLE.
  - The next frame starts on the edge after the SUM transfer, so there is a minimum of 1 idle cycle between frames.
- Latency: an EN change ahead of edge N is in snap after N. The HDR byte is valid after edge N+1.
- Throughput: 3 cycles per frame with tx_ready held high, plus 1 IDLE cycle.
- Glitch filtering: an EN toggle that reverts before the frame starts still produces a frame if snap differed from last_rep at any IDLE edge.
- Timer behaviour: the timer runs during frames. Expiry while busy sets pend_per only once; multiple expiries collapse into one flag.

Test Plan:
1. Reset, then hold EN all 0, req=0 with PERIOD_CYCLES=20 -> first frame at cycle 20 after reset: A5, C0, 65 (reason 11, status 0x00, checksum A5^C0).
2. EN3 rises at edge 5, tx_ready=1 -> tx_valid after edge 6; bytes A5, 44, E1 on three consecutive edges; busy=0 after the third.
3. Same as 2 but tx_ready=0 for 4 cycles during STAT -> tx_data held at 44 for all 4 cycles; no byte lost or duplicated.
4. req pulse coincident with EN1 rising -> exactly one frame A5, 41, E4 (reason change wins); no follow-up request frame.
5. req pulse during STAT of a change frame, with EN = 6'b000100 -> after SUM, 1 idle cycle, then A5, 84, 21.
6. Assert reset while in STAT with tx_ready=0 -> tx_valid=0 and busy=0 the next cycle. With EN unchanged and nonzero, a fresh change frame follows reset release, because last_rep is 0.
